// File: rtl/cnu_min_sum.sv
// ---------------------------------------------------------------------------
// cnu_min_sum -- Check Node Unit for an LDPC min-sum decoder.
//
// Takes the DEG variable-to-check messages of one check node. Returns DEG
// check-to-variable messages and the check parity bit, with one registered
// stage. Each output lane carries extrinsic information: its magnitude and
// sign are formed from every lane except its own.
//
// Parameters:
//   DEG    check-node degree (number of lanes)
//   IN_W   input message width, sign-magnitude ([IN_W-1] = sign)
//   OUT_W  output message width, sign-magnitude ([OUT_W-1] = sign)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous reset, active-high; clears Y and p_bit
//   en     update enable; 0 holds Y and p_bit and ignores X
//   X      packed input messages, lane i = X[i]
//   Y      packed output messages, lane i = Y[i] (registered)
//   p_bit  XOR of all input sign bits (registered)
//
// Interface: there is no valid/ready handshake. A new message set is
// accepted on every cycle with en=1, and the result appears after that edge.
//
// Build option:
//   CNU_OFFSET_EN  when defined, offset min-sum is used. Each selected
//                  magnitude is reduced by 1 (floored at 0) before
//                  saturation. When undefined, plain min-sum is used.
// ---------------------------------------------------------------------------
module cnu_min_sum #(
  parameter int DEG   = 6,
  parameter int IN_W  = 6,
  parameter int OUT_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [DEG-1:0][IN_W-1:0]    X,
  output logic [DEG-1:0][OUT_W-1:0]   Y,
  output logic                        p_bit
);

  localparam int MAG_IN_W  = IN_W - 1;
  localparam int MAG_OUT_W = OUT_W - 1;
  localparam int MAX_OUT   = (1 << MAG_OUT_W) - 1;
  localparam int IDX_W     = (DEG > 1) ? $clog2(DEG) : 1;

  logic [DEG-1:0]                s;
  logic [DEG-1:0][MAG_IN_W-1:0]  m;
  logic                          p;
  logic [MAG_IN_W-1:0]           min1;
  logic [MAG_IN_W-1:0]           min2;
  logic [IDX_W-1:0]              idx;
  logic [DEG-1:0][OUT_W-1:0]     y_next;

  // Split each lane into its sign and magnitude, and form the check parity.
  always_comb begin
    p = 1'b0;
    for (int i = 0; i < DEG; i++) begin
      s[i] = X[i][IN_W-1];
      m[i] = X[i][MAG_IN_W-1:0];
      p    = p ^ s[i];
    end
  end

  // Find the two smallest magnitudes with a single scan.
  // A strict '<' against min1 keeps idx on the lowest lane that holds the
  // minimum. A later equal value falls through to the min2 update, so a
  // repeated minimum yields min2 == min1.
  always_comb begin
    min1 = m[0];
    min2 = {MAG_IN_W{1'b1}};
    idx  = '0;
    for (int i = 1; i < DEG; i++) begin
      if (m[i] < min1) begin
        min2 = min1;
        min1 = m[i];
        idx  = IDX_W'(i);
      end else if (m[i] < min2) begin
        min2 = m[i];
      end
    end
  end

  // Per-lane extrinsic magnitude, optional offset, saturation and sign.
  always_comb begin
    logic [MAG_IN_W-1:0] mag;
    y_next = '0;
    for (int i = 0; i < DEG; i++) begin
      mag = (IDX_W'(i) == idx) ? min2 : min1;
`ifdef CNU_OFFSET_EN
      mag = (mag != '0) ? (mag - MAG_IN_W'(1)) : '0;
`endif
      // Saturate to the largest output magnitude instead of wrapping.
      if (mag > MAG_IN_W'(MAX_OUT)) begin
        y_next[i][MAG_OUT_W-1:0] = {MAG_OUT_W{1'b1}};
      end else begin
        y_next[i][MAG_OUT_W-1:0] = mag[MAG_OUT_W-1:0];
      end
      // XOR of all the other lanes' signs. The sign is kept even when the
      // magnitude is zero, so negative zero is a valid output.
      y_next[i][OUT_W-1] = p ^ s[i];
    end
  end

  // Output register. Reset takes priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y     <= '0;
      p_bit <= 1'b0;
    end else if (en) begin
      Y     <= y_next;
      p_bit <= p;
    end
  end

endmodule

// File: tb/tb_cnu_min_sum.sv
// ---------------------------------------------------------------------------
// tb_cnu_min_sum -- self-checking bench for cnu_min_sum.
// The reference model works directly from the extrinsic definition. For each
// lane it takes the minimum magnitude and the sign XOR over every other lane.
// ---------------------------------------------------------------------------
module tb_cnu_min_sum;

  localparam int DEG   = 6;
  localparam int IN_W  = 6;
  localparam int OUT_W = 5;
  localparam int W     = DEG * OUT_W + 1;

  // ---------------- clock / reset / DUT ----------------
  logic                       clk = 1'b0;
  logic                       rst;
  logic                       en;
  logic [DEG-1:0][IN_W-1:0]   X;
  logic [DEG-1:0][OUT_W-1:0]  Y;
  logic                       p_bit;

  always #5 clk = ~clk;

  cnu_min_sum #(.DEG(DEG), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .X     (X),
    .Y     (Y),
    .p_bit (p_bit)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_state;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_model(input logic [DEG-1:0][IN_W-1:0] x);
    logic [DEG-1:0][OUT_W-1:0] y;
    logic p;
    int best;
    logic sgn;
    p = 1'b0;
    for (int k = 0; k < DEG; k++) p ^= x[k][IN_W-1];
    for (int i = 0; i < DEG; i++) begin
      best = 1 << 30;
      sgn  = 1'b0;
      for (int j = 0; j < DEG; j++) begin
        if (j != i) begin
          if (int'(x[j][IN_W-2:0]) < best) best = int'(x[j][IN_W-2:0]);
          sgn ^= x[j][IN_W-1];
        end
      end
`ifdef CNU_OFFSET_EN
      if (best > 0) best = best - 1;
`endif
      if (best > (1 << (OUT_W-1)) - 1) best = (1 << (OUT_W-1)) - 1;
      y[i] = {sgn, best[OUT_W-2:0]};
    end
    return {p, y};
  endfunction

  function automatic logic [DEG-1:0][IN_W-1:0] mk_x(
      input logic [IN_W-1:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [W-1:0] mk_exp(input logic p,
      input logic [OUT_W-1:0] a0, a1, a2, a3, a4, a5);
    return {p, a5, a4, a3, a2, a1, a0};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic [DEG-1:0][IN_W-1:0] x_v,
                      input logic en_v, input logic rst_v);
    logic [W-1:0] e;
    @(negedge clk);
    X   = x_v;
    en  = en_v;
    rst = rst_v;
    if (rst_v)     model_state = '0;
    else if (en_v) model_state = ref_model(x_v);
    exp_q.push_back(model_state);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, {p_bit, Y}, e);
  endtask

  // ---------------- stimulus ----------------
  logic [DEG-1:0][IN_W-1:0] v2, v3, v4, vz, xr;
  logic [W-1:0] e2, e3, e4;

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    X   = '0;
    model_state = '0;

    v2 = mk_x(6'b110001, 6'b100001, 6'b000001, 6'b000001, 6'b100010, 6'b000010);
    v3 = mk_x(6'b110001, 6'b000010, 6'b100011, 6'b000001, 6'b110011, 6'b010010);
    v4 = {DEG{6'b011111}};
    vz = '0;
`ifdef CNU_OFFSET_EN
    e2 = mk_exp(1'b1, 5'b00000, 5'b00000, 5'b10000, 5'b10000, 5'b00000, 5'b10000);
    e3 = mk_exp(1'b1, 5'b00000, 5'b10000, 5'b00000, 5'b10001, 5'b00000, 5'b10000);
`else
    e2 = mk_exp(1'b1, 5'b00001, 5'b00001, 5'b10001, 5'b10001, 5'b00001, 5'b10001);
    e3 = mk_exp(1'b1, 5'b00001, 5'b10001, 5'b00001, 5'b10010, 5'b00001, 5'b10001);
`endif
    e4 = {1'b0, {DEG{5'b01111}}};

    // Reset, then idle with en=0.
    step("rst", mk_x(6'h3f, 6'h15, 6'h2a, 6'h01, 6'h20, 6'h33), 1'b1, 1'b1);
    step("idle_after_rst", v3, 1'b0, 1'b0);

    // Directed vectors.
    step("vec2_model", v2, 1'b1, 1'b0);
    check("vec2_const", {p_bit, Y}, e2);
    step("vec3_model", v3, 1'b1, 1'b0);
    check("vec3_const", {p_bit, Y}, e3);
    step("sat_model", v4, 1'b1, 1'b0);
    check("sat_const", {p_bit, Y}, e4);

    // Hold and then reset while enabled.
    step("reload_v3", v3, 1'b1, 1'b0);
    step("hold", vz, 1'b0, 1'b0);
    check("hold_const", {p_bit, Y}, e3);
    step("rst_over_en", v2, 1'b1, 1'b1);
    check("rst_const", {p_bit, Y}, '0);

    // Randomized traffic. Small magnitudes force ties, and a high band
    // exercises saturation.
    for (int n = 0; n < 400; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < DEG; i++) begin
        logic [IN_W-2:0] mg;
        case (mode)
          0:       mg = (IN_W-1)'($urandom_range(0, 3));
          1:       mg = (IN_W-1)'($urandom_range(0, 31));
          default: mg = (IN_W-1)'($urandom_range(14, 31));
        endcase
        xr[i] = {1'($urandom_range(0, 1)), mg};
      end
      step("rand", xr, ($urandom_range(0, 7) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
